dff_mem_stream: RTL and testbench

Parametrised flip-flop register-file memory with a command/stream front end. It supersedes the fixed 8-bit single-access DFF RAM. It supports single and burst accesses with address auto-increment and wrap-around, a ready/valid write stream, a back-pressurable registered read stream, and an optional clear on reset. It sits between the pin-mux/top wrapper and the storage array, as the data memory of the tile.

---
 rtl/dff_mem_pkg.sv | 13 +
 rtl/dff_mem_stream_if.sv | 31 +++
 rtl/dff_mem_array.sv | 33 +++
 rtl/dff_mem_stream.sv | 112 +++++++++++
 tb/tb_dff_mem_stream.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dff_mem_pkg.sv
// rtl/dff_mem_pkg.sv - shared state encoding and default widths for the DFF stream memory
package dff_mem_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

endpackage

// File: rtl/dff_mem_stream_if.sv
// rtl/dff_mem_stream_if.sv - command, write-stream and read-stream bundle of the DFF stream memory
interface dff_mem_stream_if
    import dff_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;

    modport master (
        output cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready,
        input  cmd_ready, wr_ready, rd_data, rd_valid
    );

    modport slave (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready,
        output cmd_ready, wr_ready, rd_data, rd_valid
    );

endinterface

// File: rtl/dff_mem_array.sv
// rtl/dff_mem_array.sv - flip-flop storage with one synchronous write port and one combinational read port
module dff_mem_array
    import dff_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dff_mem_stream.sv
// rtl/dff_mem_stream.sv - burst command FSM with write stream and registered, back-pressurable read stream
module dff_mem_stream
    import dff_mem_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter bit CLEAR_ON_RST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             busy,
    dff_mem_stream_if.slave  bus
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] mem_rdata;
    logic              rd_issue;
    logic              wr_fire;
    logic              mem_we;
    logic              mem_clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        rem_d         = rem_q;
        rd_data_d     = rd_data_q;
        rd_valid_d    = rd_valid_q;
        bus.cmd_ready = 1'b0;
        bus.wr_ready  = 1'b0;
        rd_issue      = 1'b0;
        wr_fire       = 1'b0;
        if (en) begin
            unique case (state_q)
                IDLE: begin
                    // A new command waits until the previous read beat has left
                    bus.cmd_ready = !rd_valid_q;
                    if (bus.cmd_valid && !rd_valid_q) begin
                        ptr_d   = bus.cmd_addr;
                        rem_d   = bus.cmd_len;
                        state_d = bus.cmd_wr ? WR : RD;
                    end
                end
                RD: begin
                    rd_issue = !rd_valid_q || bus.rd_ready;
                    if (rd_issue) begin
                        rd_data_d = mem_rdata;
                        ptr_d     = ptr_q + ADDR_ONE;
                        if (rem_q == '0) state_d = IDLE;
                        else             rem_d   = rem_q - ADDR_ONE;
                    end
                end
                WR: begin
                    bus.wr_ready = 1'b1;
                    wr_fire      = bus.wr_valid;
                    if (wr_fire) begin
                        ptr_d = ptr_q + ADDR_ONE;
                        if (rem_q == '0) state_d = IDLE;
                        else             rem_d   = rem_q - ADDR_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (rd_issue)          rd_valid_d = 1'b1;
            else if (bus.rd_ready) rd_valid_d = 1'b0;
        end
    end

    // Writes are suppressed during reset so an aborted burst cannot land one more beat
    assign mem_we    = wr_fire && !rst;
    assign mem_clear = rst && CLEAR_ON_RST;

    dff_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .clear (mem_clear),
        .we    (mem_we),
        .waddr (ptr_q),
        .wdata (bus.wr_data),
        .raddr (ptr_q),
        .rdata (mem_rdata)
    );

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign busy         = (state_q != IDLE) || rd_valid_q;

endmodule

// File: tb/tb_dff_mem_stream.sv
// tb/tb_dff_mem_stream.sv - randomized self-checking bench for dff_mem_stream against an array model
module tb_dff_mem_stream;
    import dff_mem_pkg::*;

    localparam int DW = 8;
    localparam int AW = 6;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst, en;
    logic cmd_valid, cmd_wr, wr_valid, rd_ready;
    logic [AW-1:0] cmd_addr, cmd_len;
    logic [DW-1:0] wr_data;
    logic busy_a, busy_b;

    always #5 clk = ~clk;

    dff_mem_stream_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
    dff_mem_stream_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

    assign bus_a.cmd_valid = cmd_valid;
    assign bus_a.cmd_wr    = cmd_wr;
    assign bus_a.cmd_addr  = cmd_addr;
    assign bus_a.cmd_len   = cmd_len;
    assign bus_a.wr_data   = wr_data;
    assign bus_a.wr_valid  = wr_valid;
    assign bus_a.rd_ready  = rd_ready;
    assign bus_b.cmd_valid = cmd_valid;
    assign bus_b.cmd_wr    = cmd_wr;
    assign bus_b.cmd_addr  = cmd_addr;
    assign bus_b.cmd_len   = cmd_len;
    assign bus_b.wr_data   = wr_data;
    assign bus_b.wr_valid  = wr_valid;
    assign bus_b.rd_ready  = rd_ready;

    dff_mem_stream #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .busy(busy_a), .bus(bus_a));
    dff_mem_stream #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .busy(busy_b), .bus(bus_b));

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] model_a [DEPTH];
    logic [DW-1:0] model_b [DEPTH];
    logic [DW-1:0] wbuf [DEPTH];
    logic [DW-1:0] got_a [$];
    logic [DW-1:0] got_b [$];
    int got_cyc [$];
    int stall_viol, freeze_viol;
    bit gap_pat [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    task automatic send_cmd(input logic wr, input int addr, input int len, output bit ok);
        @(negedge clk);
        en = 1'b1; cmd_valid = 1'b1; cmd_wr = wr;
        cmd_addr = AW'(addr); cmd_len = AW'(len);
        #1;
        ok = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (bus_a.cmd_ready) begin ok = 1'b1; break; end
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic write_beats(input int n, input int mode, output bit ok);
        int cnt = 0;
        for (int c = 0; c < 300 && cnt < n; c++) begin
            @(negedge clk);
            case (mode)
                0:       wr_valid = 1'b1;
                1:       wr_valid = gap_pat[c % 7];
                default: wr_valid = 1'($urandom_range(0, 1));
            endcase
            wr_data = wbuf[cnt];
            #1;
            if (wr_valid && bus_a.wr_ready) cnt++;
        end
        @(posedge clk); #1;
        wr_valid = 1'b0;
        ok = (cnt == n);
    endtask

    // Collects n consumed beats; en_off_at drops en for 3 cycles starting at that loop cycle
    task automatic read_beats(input int n, input int rmode, input int en_off_at, output bit ok);
        int cnt = 0;
        bit prev_stall = 1'b0;
        logic [DW-1:0] prev_a, snap;
        logic snap_v;
        got_a.delete(); got_b.delete(); got_cyc.delete();
        stall_viol = 0; freeze_viol = 0;
        for (int c = 0; c < 300 && cnt < n; c++) begin
            @(negedge clk);
            en = !(en_off_at >= 0 && c >= en_off_at && c < en_off_at + 3);
            case (rmode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (c % 3 == 0);
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (!en) begin
                if (c == en_off_at) begin
                    snap = bus_a.rd_data; snap_v = bus_a.rd_valid;
                end else if (bus_a.rd_data !== snap || bus_a.rd_valid !== snap_v) begin
                    freeze_viol++;
                end
                if (bus_a.cmd_ready !== 1'b0 || bus_a.wr_ready !== 1'b0) freeze_viol++;
            end else begin
                if (prev_stall && (bus_a.rd_data !== prev_a || bus_a.rd_valid !== 1'b1)) stall_viol++;
                if (bus_a.rd_valid && rd_ready) begin
                    got_a.push_back(bus_a.rd_data);
                    got_b.push_back(bus_b.rd_data);
                    got_cyc.push_back(c);
                    cnt++;
                end
                prev_stall = bus_a.rd_valid && !rd_ready;
                prev_a = bus_a.rd_data;
            end
        end
        @(posedge clk); #1;
        rd_ready = 1'b0; en = 1'b1;
        ok = (cnt == n);
    endtask

    task automatic do_read(input int addr, input int len, input int rmode, input int en_off, output bit ok);
        bit ok_c, ok_r;
        send_cmd(1'b0, addr, len, ok_c);
        read_beats(len + 1, rmode, en_off, ok_r);
        ok = ok_c && ok_r;
    endtask

    task automatic do_write(input int addr, input int len, input int mode, output bit ok);
        bit ok_c, ok_w;
        send_cmd(1'b1, addr, len, ok_c);
        write_beats(len + 1, mode, ok_w);
        ok = ok_c && ok_w;
        for (int i = 0; i <= len; i++) begin
            model_a[(addr + i) % DEPTH] = wbuf[i];
            model_b[(addr + i) % DEPTH] = wbuf[i];
        end
    endtask

    task automatic test_reset();
        bit ok;
        for (int i = 0; i < DEPTH; i++) begin model_a[i] = '0; model_b[i] = 'x; end
        @(negedge clk);
        rst = 1'b1; en = 1'b1; cmd_valid = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0; wr_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (busy_a !== 1'b0 || bus_a.rd_valid !== 1'b0 || bus_a.rd_data !== 8'h00) begin
            fails++; $display("FAIL reset_outputs: busy=%b rd_valid=%b rd_data=%h, required 0 0 00", busy_a, bus_a.rd_valid, bus_a.rd_data);
        end
        tests++;
        if (bus_a.cmd_ready !== 1'b1 || bus_a.wr_ready !== 1'b0) begin
            fails++; $display("FAIL reset_ready: cmd_ready=%b wr_ready=%b, required 1 0", bus_a.cmd_ready, bus_a.wr_ready);
        end
        do_read(5, 0, 0, -1, ok);
        tests++;
        if (!ok || got_a[0] !== 8'h00 || got_cyc[0] !== 1) begin
            fails++; $display("FAIL reset_read: ok=%b data=%h cyc=%0d, required 1 00 1", ok, got_a[0], got_cyc[0]);
        end
        @(negedge clk); #1;
        tests++;
        if (busy_a !== 1'b0 || bus_a.cmd_ready !== 1'b1) begin
            fails++; $display("FAIL reset_read_idle: busy=%b cmd_ready=%b, required 0 1", busy_a, bus_a.cmd_ready);
        end
    endtask

    task automatic test_full_depth();
        bit ok;
        int base = $urandom_range(0, DEPTH - 1);
        for (int i = 0; i < DEPTH; i++) wbuf[i] = DW'($urandom);
        do_write(base, DEPTH - 1, 2, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL full_write: accepted beats short, required %0d", DEPTH); end
        do_read(base, DEPTH - 1, 2, -1, ok);
        tests++;
        if (!ok || stall_viol !== 0) begin
            fails++; $display("FAIL full_read: ok=%b stall_viol=%0d, required 1 0", ok, stall_viol);
        end
        for (int i = 0; i < DEPTH && i < got_a.size(); i++) begin
            tests++;
            if (got_a[i] !== model_a[(base + i) % DEPTH] || got_b[i] !== model_b[(base + i) % DEPTH]) begin
                fails++; $display("FAIL full_data[%0d]: a=%h b=%h, required %h", i, got_a[i], got_b[i], model_a[(base + i) % DEPTH]);
            end
        end
    endtask

    task automatic test_wrap_back_to_back();
        bit ok;
        logic [DW-1:0] exp_v [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        for (int i = 0; i < 4; i++) wbuf[i] = exp_v[i];
        do_write(6'h3E, 3, 0, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL wrap_write: not all 4 beats accepted"); end
        do_read(6'h3E, 3, 0, -1, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL wrap_read: fewer than 4 beats"); end
        for (int i = 0; i < 4 && i < got_a.size(); i++) begin
            tests++;
            if (got_a[i] !== exp_v[i] || got_b[i] !== exp_v[i] || got_cyc[i] !== i + 1) begin
                fails++; $display("FAIL wrap_beat[%0d]: data=%h/%h cyc=%0d, required %h cyc %0d", i, got_a[i], got_b[i], got_cyc[i], exp_v[i], i + 1);
            end
        end
        @(negedge clk); #1;
        tests++;
        if (bus_a.cmd_ready !== 1'b1 || busy_a !== 1'b0) begin
            fails++; $display("FAIL wrap_next_cmd: cmd_ready=%b busy=%b, required 1 0", bus_a.cmd_ready, busy_a);
        end
    endtask

    task automatic test_rd_stall();
        bit ok;
        int base = $urandom_range(0, DEPTH - 1);
        do_read(base, 7, 1, -1, ok);
        tests++;
        if (!ok || got_a.size() != 8 || stall_viol !== 0) begin
            fails++; $display("FAIL stall_read: ok=%b beats=%0d stall_viol=%0d, required 1 8 0", ok, got_a.size(), stall_viol);
        end
        for (int i = 0; i < got_a.size(); i++) begin
            tests++;
            if (got_a[i] !== model_a[(base + i) % DEPTH] || got_b[i] !== model_b[(base + i) % DEPTH]) begin
                fails++; $display("FAIL stall_data[%0d]: a=%h b=%h, required %h", i, got_a[i], got_b[i], model_a[(base + i) % DEPTH]);
            end
        end
    endtask

    task automatic test_wr_gaps();
        bit ok;
        int base = $urandom_range(0, DEPTH - 1);
        int lo = (base + DEPTH - 1) % DEPTH;
        for (int i = 0; i < 4; i++) wbuf[i] = DW'($urandom);
        do_write(base, 3, 1, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL gap_write: 4 beats not accepted"); end
        @(negedge clk); #1;
        tests++;
        if (bus_a.wr_ready !== 1'b0 || busy_a !== 1'b0) begin
            fails++; $display("FAIL gap_idle: wr_ready=%b busy=%b, required 0 0", bus_a.wr_ready, busy_a);
        end
        do_read(lo, 5, 0, -1, ok);
        for (int i = 0; i < 6 && i < got_a.size(); i++) begin
            tests++;
            if (got_a[i] !== model_a[(lo + i) % DEPTH] || got_b[i] !== model_b[(lo + i) % DEPTH]) begin
                fails++; $display("FAIL gap_data[%0d]: a=%h b=%h, required %h", i, got_a[i], got_b[i], model_a[(lo + i) % DEPTH]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ok_c, ok_w, ok;
        int base = $urandom_range(0, DEPTH - 1);
        for (int i = 0; i < 4; i++) wbuf[i] = DW'($urandom);
        send_cmd(1'b1, base, 3, ok_c);
        write_beats(2, 0, ok_w);
        @(negedge clk);
        rst = 1'b1; wr_valid = 1'b1; wr_data = wbuf[2];
        @(negedge clk);
        rst = 1'b0; wr_valid = 1'b0;
        #1;
        tests++;
        if (!(ok_c && ok_w) || dut_a.state_q !== IDLE || bus_a.wr_ready !== 1'b0 ||
            bus_a.rd_valid !== 1'b0 || bus_a.cmd_ready !== 1'b1) begin
            fails++; $display("FAIL rst_mid: state=%0d wr_ready=%b rd_valid=%b cmd_ready=%b, required 0 0 0 1",
                              dut_a.state_q, bus_a.wr_ready, bus_a.rd_valid, bus_a.cmd_ready);
        end
        for (int i = 0; i < DEPTH; i++) model_a[i] = '0;
        model_b[base % DEPTH] = wbuf[0];
        model_b[(base + 1) % DEPTH] = wbuf[1];
        do_read(base, 3, 0, -1, ok);
        for (int i = 0; i < 4 && i < got_a.size(); i++) begin
            tests++;
            if (got_a[i] !== model_a[(base + i) % DEPTH] || got_b[i] !== model_b[(base + i) % DEPTH]) begin
                fails++; $display("FAIL rst_mid_data[%0d]: a=%h b=%h, required %h %h", i, got_a[i], got_b[i],
                                  model_a[(base + i) % DEPTH], model_b[(base + i) % DEPTH]);
            end
        end
    endtask

    task automatic test_en_freeze();
        bit ok;
        int base = $urandom_range(0, DEPTH - 1);
        for (int i = 0; i < 16; i++) wbuf[i] = DW'($urandom);
        do_write(base, 15, 0, ok);
        do_read(base, 7, 0, 3, ok);
        tests++;
        if (!ok || freeze_viol !== 0) begin
            fails++; $display("FAIL en_freeze: ok=%b freeze_viol=%0d, required 1 0", ok, freeze_viol);
        end
        for (int i = 0; i < 8 && i < got_a.size(); i++) begin
            tests++;
            if (got_a[i] !== model_a[(base + i) % DEPTH]) begin
                fails++; $display("FAIL en_data[%0d]: got %h, required %h", i, got_a[i], model_a[(base + i) % DEPTH]);
            end
        end
    endtask

    task automatic test_random_bursts();
        bit ok;
        for (int n = 0; n < 12; n++) begin
            int base = $urandom_range(0, DEPTH - 1);
            int len = $urandom_range(0, 9);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= len; i++) wbuf[i] = DW'($urandom);
                do_write(base, len, 2, ok);
            end else begin
                do_read(base, len, 2, -1, ok);
                for (int i = 0; i < got_a.size(); i++) begin
                    tests++;
                    if (got_a[i] !== model_a[(base + i) % DEPTH] || got_b[i] !== model_b[(base + i) % DEPTH]) begin
                        fails++; $display("FAIL rand_data[%0d.%0d]: a=%h b=%h, required %h", n, i, got_a[i], got_b[i], model_a[(base + i) % DEPTH]);
                    end
                end
            end
            tests++;
            if (!ok || stall_viol !== 0) begin
                fails++; $display("FAIL rand_burst[%0d]: ok=%b stall_viol=%0d, required 1 0", n, ok, stall_viol);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_depth();
        test_wrap_back_to_back();
        test_rd_stall();
        test_wr_gaps();
        test_reset_mid_burst();
        test_en_freeze();
        test_random_bursts();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule
